// File: rtl/bram_sync_one_port_be.sv
// Single-port block RAM with byte write enables, read-during-write mode select and a clear engine.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, en/we are dropped while busy.
module bram_sync_one_port_be #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int WRITE_MODE     = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                clear,
   output logic                                busy,
   input  logic                                en,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    we,
   input  logic [ADDR_WIDTH-1:0]               addr,
   input  logic [DATA_WIDTH-1:0]               din,
   output logic [DATA_WIDTH-1:0]               dout,
   output logic                                dout_valid
);

   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam bit WR_FIRST  = (WRITE_MODE == 1);
   localparam bit NO_CHANGE = (WRITE_MODE == 2);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if ((DATA_WIDTH % BYTE_WIDTH) != 0 || WRITE_MODE > 2 || WRITE_MODE < 0) begin : g_bad_param
      $error("bram_sync_one_port_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and WRITE_MODE in 0..2");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
   localparam bit     RST_BUSY  = (CLEAR_ON_RESET != 0);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic                    busy_q, busy_d;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_rd;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    acc;
   logic                    wr;
   logic                    rd_load;

   logic [DATA_WIDTH-1:0]   s1_dat_q, s1_dat_d;
   logic                    s1_vld_q, s1_vld_d;

   // Clear engine: one word per cycle, clear requests ignored while running.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d = ST_CLEAR;
               busy_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RST_STATE;
         clr_cnt_q <= '0;
         busy_q    <= RST_BUSY;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;

   assign acc    = en & ~busy_q;
   assign wr     = acc & (|we);
   assign mem_rd = mem[addr];

   always_comb begin
      merged = mem_rd;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (we[i]) begin
            merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Array itself is never reset; the clear engine owns the write port while busy.
   always_ff @(posedge clk) begin
      if (busy_q) begin
         mem[clr_cnt_q] <= '0;
      end else if (wr) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (we[i]) begin
               mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   assign rd_load = acc & ~(NO_CHANGE & wr);

   always_comb begin
      s1_dat_d = s1_dat_q;
      s1_vld_d = rd_load;
      if (rd_load) begin
         s1_dat_d = (WR_FIRST && wr) ? merged : mem_rd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_dat_q <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_dat_q <= s1_dat_d;
         s1_vld_q <= s1_vld_d;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_dat_q, s2_dat_d;
      logic                  s2_vld_q, s2_vld_d;

      always_comb begin
         s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
         s2_vld_d = s1_vld_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s2_dat_q <= '0;
            s2_vld_q <= 1'b0;
         end else begin
            s2_dat_q <= s2_dat_d;
            s2_vld_q <= s2_vld_d;
         end
      end

      assign dout       = s2_dat_q;
      assign dout_valid = s2_vld_q;
   end else begin : g_no_out_reg
      assign dout       = s1_dat_q;
      assign dout_valid = s1_vld_q;
   end

endmodule

// File: tb/tb_bram_sync_one_port_be.sv
// Bench for bram_sync_one_port_be: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST+OUT_REG)
// share one stimulus stream and are checked against a word-level model plus literal expectations.
module tb_bram_sync_one_port_be;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clear;
   logic          en;
   logic [NB-1:0] we;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;

   logic [DW-1:0] dout_w [4];
   logic          dv_w   [4];
   logic          busy_w [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      bram_sync_one_port_be #(
         .ADDR_WIDTH    (AW),
         .DATA_WIDTH    (DW),
         .BYTE_WIDTH    (8),
         .WRITE_MODE    ((g == 3) ? 0 : g),
         .OUT_REG       ((g == 3) ? 1 : 0),
         .CLEAR_ON_RESET(1)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .clear      (clear),
         .busy       (busy_w[g]),
         .en         (en),
         .we         (we),
         .addr       (addr),
         .din        (din),
         .dout       (dout_w[g]),
         .dout_valid (dv_w[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: word array, remaining clear cycles, and per-instance delivery after 1 or 2 edges.
   logic [31:0] mm [DEPTH];
   int          clr_left;
   logic [31:0] m_dout [4];
   logic        m_vld  [4];
   logic        pend_v [4];
   logic [31:0] pend_d [4];
   logic        res_v  [4];
   logic [31:0] res_d  [4];
   logic [31:0] old_w, new_w;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_left = DEPTH;
         for (int a = 0; a < DEPTH; a++) mm[a] = '0;
         for (int k = 0; k < 4; k++) begin
            m_dout[k] = '0;
            m_vld[k]  = 1'b0;
            pend_v[k] = 1'b0;
            pend_d[k] = '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            res_v[k] = 1'b0;
            res_d[k] = '0;
         end
         if (clr_left > 0) begin
            clr_left--;
         end else begin
            if (en) begin
               old_w = mm[addr];
               new_w = old_w;
               for (int b = 0; b < NB; b++) if (we[b]) new_w[b*8 +: 8] = din[b*8 +: 8];
               for (int k = 0; k < 4; k++) begin
                  int mode;
                  mode     = (k == 3) ? 0 : k;
                  res_v[k] = !(mode == 2 && we != 0);
                  res_d[k] = (mode == 1) ? new_w : old_w;
               end
               mm[addr] = new_w;
            end
            if (clear) begin
               clr_left = DEPTH;
               for (int a = 0; a < DEPTH; a++) mm[a] = '0;
            end
         end
         for (int k = 0; k < 3; k++) begin
            m_vld[k] = res_v[k];
            if (res_v[k]) m_dout[k] = res_d[k];
         end
         m_vld[3] = pend_v[3];
         if (pend_v[3]) m_dout[3] = pend_d[3];
         pend_v[3] = res_v[3];
         pend_d[3] = res_d[3];
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("model_dout[%0d]", k), dout_w[k], m_dout[k]);
         chk($sformatf("model_valid[%0d]", k), 32'(dv_w[k]), 32'(m_vld[k]));
         chk($sformatf("model_busy[%0d]", k), 32'(busy_w[k]), 32'(clr_left > 0));
      end
   end

   task automatic step(input logic e, input logic [3:0] w, input logic [3:0] a, input logic [31:0] d);
      en   = e;
      we   = w;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy_len(input string name);
      int n;
      n = 0;
      while (busy_w[0] === 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, 32'(n), 32'd16);
   endtask

   initial begin
      clear   = 1'b0;
      en      = 1'b0;
      we      = '0;
      addr    = '0;
      din     = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk("reset_busy", 32'(busy_w[0]), 32'd1);
      chk("reset_dout", dout_w[0], 32'd0);
      chk("reset_valid", 32'(dv_w[3]), 32'd0);
      #20 reset_n = 1'b1;
      wait_busy_len("busy_len_after_reset");

      for (int a = 0; a < DEPTH; a++) begin
         step(1'b1, 4'h0, 4'(a), 32'h0);
         chk("initial_read_valid", 32'(dv_w[0]), 32'd1);
         chk("initial_read_zero", dout_w[0], 32'd0);
      end
      step(1'b0, 4'h0, 4'h0, 32'h0);

      step(1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
      step(1'b1, 4'b0101, 4'd5, 32'h11223344);
      chk("rdw_read_first", dout_w[0], 32'hDEADBEEF);
      chk("rdw_write_first", dout_w[1], 32'hDE22BE44);
      chk("rdw_no_change_valid", 32'(dv_w[2]), 32'd0);
      chk("rdw_no_change_hold", dout_w[2], 32'd0);
      step(1'b1, 4'h0, 4'd5, 32'h0);
      chk("merged_readback", dout_w[0], 32'hDE22BE44);
      chk("merged_readback_nc", dout_w[2], 32'hDE22BE44);

      step(1'b1, 4'hF, 4'd3, 32'hCAFEF00D);
      chk("nc_write_valid", 32'(dv_w[2]), 32'd0);
      chk("nc_write_hold", dout_w[2], 32'hDE22BE44);
      step(1'b1, 4'h0, 4'd3, 32'h0);
      chk("nc_read_valid", 32'(dv_w[2]), 32'd1);
      chk("nc_read_data", dout_w[2], 32'hCAFEF00D);

      step(1'b0, 4'h0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 4'(i), 32'h0BAD0000 + 32'(i));
      step(1'b0, 4'h0, 4'h0, 32'h0);
      step(1'b0, 4'h0, 4'h0, 32'h0);
      for (int e = 1; e <= 6; e++) begin
         if (e <= 4) step(1'b1, 4'h0, 4'(e - 1), 32'h0);
         else        step(1'b0, 4'h0, 4'h0, 32'h0);
         chk("outreg_valid", 32'(dv_w[3]), 32'((e >= 2) && (e <= 5)));
         if (e >= 2 && e <= 5) chk("outreg_data", dout_w[3], 32'h0BAD0000 + 32'(e - 2));
      end

      clear = 1'b1;
      step(1'b1, 4'hF, 4'd7, 32'h77777777);
      clear = 1'b0;
      chk("clear_busy_rise", 32'(busy_w[0]), 32'd1);
      chk("clear_same_cycle_access", 32'(dv_w[0]), 32'd1);
      begin
         int n;
         n = 0;
         while (busy_w[0] === 1'b1 && n < 100) begin
            clear = (n == 7);
            step(1'b1, 4'hF, 4'(n), 32'hFFFFFFFF);
            n++;
         end
         clear = 1'b0;
         chk("busy_len_with_repulse", 32'(n), 32'd16);
      end
      for (int a = 0; a < DEPTH; a++) step(1'b1, 4'h0, 4'(a), 32'h0);
      chk("cleared_word15", dout_w[0], 32'd0);
      step(1'b1, 4'h0, 4'd7, 32'h0);
      chk("cleared_word7", dout_w[0], 32'd0);

      step(1'b1, 4'hF, 4'd9, 32'h12345678);
      step(1'b1, 4'h0, 4'd9, 32'h0);
      chk("pre_reset_read", dout_w[0], 32'h12345678);
      step(1'b0, 4'h0, 4'h0, 32'h0);
      clear = 1'b1;
      step(1'b0, 4'h0, 4'h0, 32'h0);
      clear = 1'b0;
      repeat (7) step(1'b0, 4'h0, 4'h0, 32'h0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_dout", dout_w[0], 32'd0);
      chk("async_reset_valid", 32'(dv_w[0]), 32'd0);
      chk("async_reset_busy", 32'(busy_w[1]), 32'd1);
      #10 reset_n = 1'b1;
      wait_busy_len("busy_len_after_midclear_reset");
      for (int a = 0; a < DEPTH; a++) step(1'b1, 4'h0, 4'(a), 32'h0);
      step(1'b1, 4'h0, 4'd9, 32'h0);
      chk("post_reset_word9", dout_w[0], 32'd0);
      step(1'b0, 4'h0, 4'h0, 32'h0);
      step(1'b0, 4'h0, 4'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
